// File: rtl/i2s_sample_transmitter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// i2s_sample_transmitter
//
// I2S slave transmitter, the microphone end of the audio capture link.
// It oversamples the externally generated bclk/lrclk on the system clock.
// It serialises queued two's-complement samples MSB-first onto dout in the
// channel slot chosen by sel, using the standard I2S one-bit delay.
// Once the sample bits are out, the rest of the active slot is driven as 0.
// dout_oe is high for the whole active slot and low for the other one.
//
// Parameters:
//   SAMPLE_BITS  sample width transmitted per slot
//   SLOT_BITS    bclk periods per lrclk half-frame
//   SYNC_STAGES  synchroniser depth for bclk/lrclk (>= 2)
//
// Ports:
//   clk         system clock, at least 8x the bclk frequency
//   reset       synchronous, active-low
//   bclk        asynchronous bit clock from the I2S master
//   lrclk       asynchronous word select (0 = left, 1 = right)
//   sel         slot this block drives (0 = left, 1 = right), quasi-static
//   s_data      sample to transmit, two's complement
//   s_valid     s_data valid
//   s_ready     holding register empty
//   dout        serial data, 0 whenever dout_oe is low
//   dout_oe     high while driving the active slot (pad tristate enable)
//   slot_start  one-clk pulse when the active slot's MSB is driven
//   underrun    one-clk pulse when an active slot starts with nothing queued
// ---------------------------------------------------------------------------
module i2s_sample_transmitter #(
    parameter int SAMPLE_BITS = 18,
    parameter int SLOT_BITS   = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   bclk,
    input  logic                   lrclk,
    input  logic                   sel,
    input  logic [SAMPLE_BITS-1:0] s_data,
    input  logic                   s_valid,
    output logic                   s_ready,
    output logic                   dout,
    output logic                   dout_oe,
    output logic                   slot_start,
    output logic                   underrun
);

    localparam int                POS_W        = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
    localparam logic [POS_W-1:0]  POS_LAST     = POS_W'(SLOT_BITS - 1);
    localparam logic [POS_W:0]    POS_DATA_END = (POS_W + 1)'(SAMPLE_BITS);

    logic [SYNC_STAGES-1:0] r_bclkSync;
    logic [SYNC_STAGES-1:0] r_lrclkSync;
    logic                   r_bclkPrev;

    logic                   r_wsLat;
    logic                   r_wsPrev;
    logic [POS_W-1:0]       r_pos;
    logic [SAMPLE_BITS-1:0] r_shift;
    logic [SAMPLE_BITS-1:0] r_hold;
    logic                   r_holdFull;
    logic                   r_releasePending;
    logic                   r_dout;
    logic                   r_doutOe;
    logic                   r_slotStart;
    logic                   r_underrun;

    logic                   w_bclkSync;
    logic                   w_lrclkSync;
    logic                   w_bclkRise;
    logic                   w_bclkFall;
    logic                   w_boundary;
    logic                   w_activeBoundary;
    logic                   w_accept;
    logic                   w_inData;
    logic [SAMPLE_BITS-1:0] w_loadValue;

    assign w_bclkSync       = r_bclkSync[SYNC_STAGES-1];
    assign w_lrclkSync      = r_lrclkSync[SYNC_STAGES-1];
    assign w_bclkRise       = w_bclkSync & ~r_bclkPrev;
    assign w_bclkFall       = ~w_bclkSync & r_bclkPrev;

    // A slot boundary is a falling bclk edge after the latched word select
    // has changed. That gives the one-bit delay after the lrclk transition.
    assign w_boundary       = w_bclkFall & (r_wsLat != r_wsPrev);
    assign w_activeBoundary = w_boundary & (r_wsLat == sel);

    // An empty holding register loads zero, so an underrun slot is silent.
    assign w_loadValue      = r_holdFull ? r_hold : '0;
    assign w_accept         = s_valid & ~r_holdFull;
    assign w_inData         = ({1'b0, r_pos} < POS_DATA_END);

    assign s_ready          = ~r_holdFull;
    assign dout             = r_dout;
    assign dout_oe          = r_doutOe;
    assign slot_start       = r_slotStart;
    assign underrun         = r_underrun;

    // Bring bclk and lrclk into the clk domain. Both chains have the same
    // depth, so the lrclk level seen at a bclk edge matches the pins.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_bclkSync  <= '0;
            r_lrclkSync <= '0;
            r_bclkPrev  <= 1'b0;
        end else begin
            r_bclkSync  <= {r_bclkSync[SYNC_STAGES-2:0], bclk};
            r_lrclkSync <= {r_lrclkSync[SYNC_STAGES-2:0], lrclk};
            r_bclkPrev  <= w_bclkSync;
        end
    end

    // The master changes lrclk on falling bclk, so it is sampled on rising
    // bclk. The reset value of 1 makes the first low lrclk start a left slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wsLat <= 1'b1;
        end else if (w_bclkRise) begin
            r_wsLat <= w_lrclkSync;
        end
    end

    // Slot sequencer and serialiser.
    // The position counter saturates instead of wrapping. A lost word-select
    // edge therefore produces continuous zeros rather than repeated data.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wsPrev    <= 1'b1;
            r_pos       <= POS_LAST;
            r_shift     <= '0;
            r_dout      <= 1'b0;
            r_doutOe    <= 1'b0;
            r_slotStart <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_slotStart <= 1'b0;
            r_underrun  <= 1'b0;
            if (w_bclkFall) begin
                if (w_boundary) begin
                    r_wsPrev <= r_wsLat;
                    r_pos    <= POS_W'(1);
                    if (r_wsLat == sel) begin
                        r_shift     <= w_loadValue;
                        r_dout      <= w_loadValue[SAMPLE_BITS-1];
                        r_doutOe    <= 1'b1;
                        r_slotStart <= 1'b1;
                        r_underrun  <= ~r_holdFull;
                    end else begin
                        r_dout   <= 1'b0;
                        r_doutOe <= 1'b0;
                    end
                end else begin
                    if (r_doutOe && w_inData) begin
                        r_shift <= {r_shift[SAMPLE_BITS-2:0], 1'b0};
                        r_dout  <= r_shift[SAMPLE_BITS-2];
                    end else begin
                        r_dout  <= 1'b0;
                    end
                    if (r_pos != POS_LAST) begin
                        r_pos <= r_pos + 1'b1;
                    end
                end
            end
        end
    end

    // Single-entry holding register.
    // A load empties the register one clk after it is consumed, so s_ready
    // comes back exactly one clk after the slot starts. A sample accepted on
    // the same clk as an underrun load is kept for the next active slot.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_hold           <= '0;
            r_holdFull       <= 1'b0;
            r_releasePending <= 1'b0;
        end else begin
            r_releasePending <= w_activeBoundary & r_holdFull;
            if (w_accept) begin
                r_hold     <= s_data;
                r_holdFull <= 1'b1;
            end else if (r_releasePending) begin
                r_holdFull <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2s_sample_transmitter.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_i2s_sample_transmitter
//
// Acts as the I2S master: drives bclk at clk/8 with 32-bit slots.
// An I2S receiver samples dout/dout_oe on every rising bclk.
// A frame-level model predicts every slot word and the pulse counts.
// The model tracks which queued sample each active slot carries, or
// whether the slot should be an all-zero underrun.
// ---------------------------------------------------------------------------
module tb_i2s_sample_transmitter;

    localparam int SAMPLE_BITS = 18;
    localparam int SLOT_BITS   = 32;
    localparam int PAD_BITS    = SLOT_BITS - SAMPLE_BITS;

    logic                   clk     = 1'b0;
    logic                   reset   = 1'b0;
    logic                   bclk    = 1'b0;
    logic                   lrclk   = 1'b1;
    logic                   sel     = 1'b0;
    logic [SAMPLE_BITS-1:0] s_data  = '0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic                   dout;
    logic                   dout_oe;
    logic                   slot_start;
    logic                   underrun;

    i2s_sample_transmitter #(
        .SAMPLE_BITS(SAMPLE_BITS),
        .SLOT_BITS  (SLOT_BITS),
        .SYNC_STAGES(2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bclk      (bclk),
        .lrclk     (lrclk),
        .sel       (sel),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .dout      (dout),
        .dout_oe   (dout_oe),
        .slot_start(slot_start),
        .underrun  (underrun)
    );

    always #5 clk = ~clk;

    int checkCount = 0;
    int passCount  = 0;

    logic [SAMPLE_BITS-1:0] feedQ[$];
    logic [SAMPLE_BITS-1:0] accData[$];
    time                    accTime[$];

    int          expStarts    = 0;
    int          expUnderruns = 0;
    int          gotStarts    = 0;
    int          gotUnderruns = 0;
    logic        lPrev        = 1'b1;
    logic        modelWsPrev  = 1'b1;
    bit          tracking     = 1'b0;
    bit          trackActive  = 1'b0;
    logic [31:0] expWord      = '0;
    logic [31:0] rxWord       = '0;
    logic [31:0] rxOe         = '0;
    int          rxCount      = 0;
    int          slotNum      = 0;
    bit          prevStart    = 1'b0;
    bit          acceptSeen   = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Queue a sample for the feeder process.
    task automatic applyStimulus(input logic [SAMPLE_BITS-1:0] sample);
        feedQ.push_back(sample);
    endtask

    // Reset empties the holding register and returns word select to "right".
    task automatic resetModel();
        lPrev       = 1'b1;
        modelWsPrev = 1'b1;
        tracking    = 1'b0;
        accData.delete();
        accTime.delete();
    endtask

    // Receiver plus reference model, run once per rising bclk.
    // A slot begins on the falling edge after a change in the word select
    // that was latched at the previous rising edge.
    task automatic modelBit(input time fallTime, input logic d, input logic oe);
        logic [SAMPLE_BITS-1:0] smp;
        if (lPrev != modelWsPrev) begin
            modelWsPrev = lPrev;
            tracking    = 1'b1;
            rxCount     = 0;
            rxWord      = '0;
            rxOe        = '0;
            trackActive = (lPrev == sel);
            expWord     = '0;
            if (trackActive) begin
                expStarts++;
                if (accData.size() > 0 && accTime[0] < fallTime) begin
                    smp     = accData.pop_front();
                    void'(accTime.pop_front());
                    expWord = {smp, {PAD_BITS{1'b0}}};
                end else begin
                    expUnderruns++;
                end
            end
        end
        if (tracking) begin
            rxWord = {rxWord[30:0], d};
            rxOe   = {rxOe[30:0], oe};
            rxCount++;
            if (rxCount == SLOT_BITS) begin
                checkOutput($sformatf("slot%0d_data", slotNum), rxWord, expWord);
                checkOutput($sformatf("slot%0d_oe", slotNum), rxOe,
                            trackActive ? 32'hFFFF_FFFF : 32'h0);
                slotNum++;
                tracking = 1'b0;
            end
        end
    endtask

    // One bclk period: the falling edge (with the new lrclk), then the
    // rising edge where the receiver samples.
    task automatic driveBclkPeriod(input logic lr);
        time fallTime;
        bclk     = 1'b0;
        lrclk    = lr;
        fallTime = $time;
        repeat (4) @(negedge clk);
        if (reset) modelBit(fallTime, dout, dout_oe);
        bclk = 1'b1;
        if (reset) lPrev = lr;
        repeat (4) @(negedge clk);
    endtask

    task automatic runFrame();
        for (int i = 0; i < SLOT_BITS; i++) driveBclkPeriod(1'b0);
        for (int i = 0; i < SLOT_BITS; i++) driveBclkPeriod(1'b1);
    endtask

    // Feeder: holds s_valid high while samples are queued.
    initial begin
        int waited;
        forever begin
            @(negedge clk);
            if (feedQ.size() == 0 || !reset) begin
                s_valid = 1'b0;
                continue;
            end
            s_data  = feedQ[0];
            s_valid = 1'b1;
            waited  = 0;
            do begin
                @(posedge clk);
                waited++;
            end while (!(s_ready && reset) && waited < 5000);
            if (!(s_ready && reset)) checkOutput("acceptTimeout", 1, 0);
            void'(feedQ.pop_front());
        end
    end

    // Record every handshake together with the time it happened.
    always @(posedge clk) begin
        if (reset && s_valid && s_ready) begin
            accData.push_back(s_data);
            accTime.push_back($time);
            acceptSeen = 1'b1;
        end
    end

    // Pulse and handshake monitor.
    always @(negedge clk) begin
        if (reset) begin
            if (slot_start) begin
                gotStarts++;
                checkOutput("slotStartWidth", prevStart, 0);
            end
            if (underrun) begin
                gotUnderruns++;
                checkOutput("underrunWithStart", slot_start, 1);
            end
            if (prevStart) checkOutput("readyAfterLoad", s_ready, 1);
            if (acceptSeen) checkOutput("readyDropAfterAccept", s_ready, 0);
        end
        acceptSeen = 1'b0;
        prevStart  = slot_start;
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: observed no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [SAMPLE_BITS-1:0] sample;

        // Reset held for 5 clk with bclk toggling.
        reset = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            checkOutput($sformatf("reset%0d", i),
                        {dout, dout_oe, s_ready, slot_start, underrun}, 5'b00100);
            bclk  = ~bclk;
            lrclk = 1'($urandom);
            @(negedge clk);
        end
        bclk  = 1'b0;
        lrclk = 1'b1;
        @(negedge clk);
        reset = 1'b1;
        resetModel();
        driveBclkPeriod(1'b1);
        driveBclkPeriod(1'b1);

        $display("[TB] left slot sample");
        sel = 1'b0;
        applyStimulus(18'h2A5C3);
        runFrame();

        $display("[TB] left slot underrun");
        runFrame();

        $display("[TB] right slot extremes");
        sel = 1'b1;
        applyStimulus(18'h1FFFF);
        runFrame();
        applyStimulus(18'h20000);
        runFrame();

        $display("[TB] back-to-back samples");
        sel = 1'b0;
        applyStimulus(18'd1);
        applyStimulus(18'd2);
        applyStimulus(18'd3);
        runFrame();
        runFrame();
        runFrame();

        $display("[TB] reset mid-slot");
        applyStimulus(18'($urandom));
        for (int i = 0; i < 9; i++) driveBclkPeriod(1'b0);
        applyStimulus(18'($urandom));
        for (int i = 0; i < 100 && feedQ.size() != 0; i++) @(negedge clk);
        checkOutput("feedDrained", feedQ.size(), 0);
        repeat (2) @(negedge clk);
        checkOutput("preResetOe", dout_oe, 1);
        reset = 1'b0;
        resetModel();
        @(negedge clk);
        checkOutput("midResetOutputs", {dout, dout_oe}, 2'b00);
        for (int i = 9; i < SLOT_BITS; i++) driveBclkPeriod(1'b0);
        for (int i = 0; i < 9; i++) driveBclkPeriod(1'b1);
        reset = 1'b1;
        @(negedge clk);
        checkOutput("readyAfterReset", s_ready, 1);
        for (int i = 9; i < SLOT_BITS; i++) driveBclkPeriod(1'b1);
        runFrame();

        $display("[TB] random frames");
        for (int f = 0; f < 6; f++) begin
            sel = 1'($urandom);
            if ($urandom_range(0, 9) < 7) begin
                sample = 18'($urandom);
                applyStimulus(sample);
            end
            runFrame();
        end
        driveBclkPeriod(1'b0);
        repeat (4) @(negedge clk);

        checkOutput("slotStartCount", gotStarts, expStarts);
        checkOutput("underrunCount", gotUnderruns, expUnderruns);
        checkOutput("feedEmpty", feedQ.size(), 0);

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/i2s_sample_transmitter.md
# i2s_sample_transmitter

I2S slave transmitter: the microphone end of the audio capture link. It receives externally generated BCLK and LRCLK, oversamples them on the system clock, and serialises queued 18-bit two's-complement samples MSB-first onto DOUT in the selected channel slot, with standard I2S one-bit delay. It serves as a synthesizable stand-in for the MEMS microphone, for loopback tests of the capture path, and as a DAC-style source on boards without a microphone.

## Interface
Parameters:
- SAMPLE_BITS, 18, sample width transmitted per slot.
- SLOT_BITS, 32, BCLK periods per LRCLK half-frame.
- SYNC_STAGES, 2, synchroniser depth for bclk/lrclk (≥2).

Ports:
- clk  in  1  system clock; must be ≥8× bclk frequency.
- reset  in  1  synchronous, active-low.
- bclk  in  1  asynchronous bit clock from the I2S master.
- lrclk  in  1  asynchronous word select; 0 = left, 1 = right.
- sel  in  1  channel this block drives: 0 = left slot, 1 = right slot; quasi-static.
- s_data  in  SAMPLE_BITS  sample, two's complement.
- s_valid  in  1  s_data valid.
- s_ready  out  1  holding register empty.
- dout  out  1  serial data; 0 whenever dout_oe = 0.
- dout_oe  out  1  high while driving the active slot (pad tristate enable).
- slot_start  out  1  one-clk pulse when the active slot's MSB is driven.
- underrun  out  1  one-clk pulse when the active slot started with no sample queued.

## Operation
- bclk and lrclk each pass through SYNC_STAGES flops, then one extra flop for edge detection. rise = sync & ~prev; fall = ~sync & prev.
- On rise: ws_lat <= lrclk_sync. lrclk is stable at BCLK rising edges.
- On fall: if ws_lat != ws_prev, a slot boundary occurs. Set ws_prev <= ws_lat and pos <= 1.
  - If ws_lat == sel, this is the active slot:
    - Load the shift register from the holding register and clear hold_full.
    - If hold_full was 0, load zero and pulse underrun.
    - Drive dout = shift MSB and set dout_oe = 1. Pulse slot_start.
  - Otherwise, this is the inactive slot: set dout_oe = 0 and dout = 0.
- On fall with no boundary:
  - pos < SAMPLE_BITS in the active slot: drive the next bit (SAMPLE_BITS-1-pos). Increment pos.
  - SAMPLE_BITS ≤ pos < SLOT_BITS: dout = 0, dout_oe unchanged. pos increments.
  - pos saturates at SLOT_BITS-1. It never wraps. A missing WS edge yields continuous zeros.
- Handshake:
  - s_ready = ~hold_full.
  - Accept when s_valid & s_ready; hold_full <= 1.
  - If a load and s_valid coincide while hold_full = 1, no accept occurs; s_ready rises the next clk.
  - If a load and an accept coincide while hold_full = 0, the load sees empty (underrun). The new sample is held for the next active slot.
- Samples are transmitted unmodified (no offset, no sign change).
- Reset values:
  - dout = 0, dout_oe = 0, s_ready = 1, slot_start = 0, underrun = 0.
  - hold_full = 0, shift = 0, pos = SLOT_BITS-1.
  - ws_lat = ws_prev = 1, so the first lrclk low after reset starts a left slot.
  - Synchroniser/edge flops are loaded with 0.
- Reset mid-slot: dout and dout_oe drop the clk after reset is sampled low. The queued sample is discarded. Transmission resumes at the first WS change observed after release.

## Timing
- Latency from a pin bclk falling edge to a dout update is SYNC_STAGES+2 clk (4 at default). This is ≤ half a BCLK period at the 8× minimum, so dout is stable at the next BCLK rising edge.
- MSB appears on the first BCLK falling edge after the rising edge that latched the new LRCLK level. This is the I2S one-bit delay; the receiver samples the MSB at the second rising edge after the WS change.
- slot_start and underrun assert in the same clk that dout takes the MSB.
- s_ready reasserts exactly 1 clk after the load that consumed the holding register.
- Bits SAMPLE_BITS..SLOT_BITS-1 of the active slot are 0 with dout_oe = 1.

## Test plan
- Reset: hold reset low 5 clk with bclk toggling → dout = 0, dout_oe = 0, s_ready = 1, slot_start = 0, underrun = 0 throughout.
- Left slot, sel = 0, bclk = clk/8, 32-bit slots: push 18'h2A5C3 → a bench I2S receiver captures 18'h2A5C3 in the LRCLK-low slot. Remaining 14 bits = 0. dout_oe = 0 for the entire LRCLK-high slot.
- Right slot, sel = 1: push 18'h1FFFF then 18'h20000 → consecutive right slots capture 18'h1FFFF and 18'h20000. The left slots show dout_oe = 0.
- Underrun: no sample queued at the left boundary → underrun is a 1-clk pulse coincident with slot_start. All 32 bits = 0. s_ready stays 1.
- Back-to-back: hold s_valid high with samples 1, 2, 3 → s_ready drops after each accept and rises 1 clk after each slot_start. Slots deliver 1, 2, 3 in order with no underrun.
- Reset mid-slot: assert reset after bit 7 of an active slot → dout/dout_oe = 0 the next clk. After release, the old sample is not sent. The next active slot underruns unless a new sample is pushed.
